micro_uart_apb_bridge: RTL and testbench

- Serial-command-to-APB initiator.
- Takes received bytes from a micro UART receiver and parses simple read/write commands from them.
- Executes each command as an APB master transaction, then returns response bytes to the UART transmitter.
- Lets a host PC drive any APB responder on the bus, including micro_uart_apb itself, over the serial line.

---
 rtl/micro_uart_apb_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_micro_uart_apb_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_uart_apb_bridge.sv
// micro_uart_apb_bridge: turns serial command bytes into APB master transactions.
//   Write command: 0x57, addr, dH, dL -> one APB write, reply 0x4B.
//   Read command : 0x52, addr         -> one APB read,  reply dH, dL.
//   Unknown opcode -> reply 0x3F.
// Optional build macro MICRO_UART_APB_BRIDGE_PREADY_EN adds apb_pready /
// apb_pslverr: wait states (abort reply 0x54) and slave error (reply 0x45).
// The current FSM state is visible on dbg_state.
//
// Response handshake: tx_valid rises together with a new tx_data and both stay
// frozen until a rising clock edge sees tx_valid & tx_ready; only that edge
// may change tx_data or drop tx_valid. rx_valid is a one-cycle pulse with no
// back-pressure; bytes arriving while busy are discarded and flagged on rx_drop.
module micro_uart_apb_bridge #(
   parameter int          ADDR_W      = 4,
   parameter logic [15:0] CMD_TIMEOUT = 16'd4000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_drop,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              apb_psel,
   output logic              apb_penable,
   output logic              apb_pwrite,
   output logic [ADDR_W-1:0] apb_paddr,
   output logic [31:0]       apb_pwdata,
   input  logic [31:0]       apb_prdata,
`ifdef MICRO_UART_APB_BRIDGE_PREADY_EN
   input  logic              apb_pready,
   input  logic              apb_pslverr,
`endif
   output logic [2:0]        dbg_state
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_GET_ADDR = 3'd1;
   localparam logic [2:0] S_GET_DH   = 3'd2;
   localparam logic [2:0] S_GET_DL   = 3'd3;
   localparam logic [2:0] S_SETUP    = 3'd4;
   localparam logic [2:0] S_ACCESS   = 3'd5;
   localparam logic [2:0] S_RESP_HI  = 3'd6;
   localparam logic [2:0] S_RESP_LO  = 3'd7;

   localparam logic [7:0] OP_WRITE  = 8'h57;
   localparam logic [7:0] OP_READ   = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_BAD   = 8'h3F;
   localparam logic [7:0] RSP_ERR   = 8'h45;
   localparam logic [7:0] RSP_TMO   = 8'h54;

   logic [2:0]        state;
   logic              is_wr_q;      // opcode of the command being parsed
   logic [ADDR_W-1:0] addr_q;       // parsed address, copied to apb_paddr at SETUP entry
   logic [7:0]        wd_hi_q;      // parsed high data byte
   logic [15:0]       wdata_q;      // drives pwdata[15:0]; held between transactions
   logic [7:0]        rd_lo_q;      // low read byte waiting behind the high byte
   logic [15:0]       cnt;          // inter-byte timeout counter
   logic              in_get;
   logic              busy;
   logic              cmd_expire;
   logic              pready_w;
   logic              pslverr_w;
   logic              acc_expire;
   logic              tx_fire;
   logic              unused_prdata;

   assign unused_prdata = ^apb_prdata[31:16];

   assign in_get     = (state == S_GET_ADDR) || (state == S_GET_DH) || (state == S_GET_DL);
   assign busy       = (state == S_SETUP) || (state == S_ACCESS) ||
                       (state == S_RESP_HI) || (state == S_RESP_LO);
   assign cmd_expire = (cnt == CMD_TIMEOUT - 16'd1);
   assign tx_fire    = tx_valid && tx_ready;

   // APB strobes decode straight from the state so a reset drops them at once
   assign apb_psel    = (state == S_SETUP) || (state == S_ACCESS);
   assign apb_penable = (state == S_ACCESS);
   assign apb_pwdata  = {16'h0000, wdata_q};
   assign dbg_state   = state;

`ifdef MICRO_UART_APB_BRIDGE_PREADY_EN
   logic [15:0] acc_cnt;

   assign pready_w   = apb_pready;
   assign pslverr_w  = apb_pslverr;
   assign acc_expire = !apb_pready && (acc_cnt == CMD_TIMEOUT - 16'd1);

   // count ACCESS cycles spent waiting for pready, saturating
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_cnt <= 16'd0;
      end else if ((state == S_ACCESS) && !apb_pready) begin
         if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      end else begin
         acc_cnt <= 16'd0;
      end
   end
`else
   assign pready_w   = 1'b1;
   assign pslverr_w  = 1'b0;
   assign acc_expire = 1'b0;
`endif

   // inter-byte timeout: cleared by any byte, runs only while parsing, saturates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 16'd0;
      end else if (rx_valid || !in_get) begin
         cnt <= 16'd0;
      end else if (cnt != 16'hFFFF) begin
         cnt <= cnt + 16'd1;
      end
   end

   // flag bytes that arrive while a transaction or response is in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rx_drop <= 1'b0;
      else          rx_drop <= rx_valid && busy;
   end

   // command parser, APB sequencer and response generator
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         wd_hi_q    <= 8'h00;
         wdata_q    <= 16'h0000;
         rd_lo_q    <= 8'h00;
         apb_paddr  <= '0;
         apb_pwrite <= 1'b0;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                     is_wr_q <= (rx_data == OP_WRITE);
                     state   <= S_GET_ADDR;
                  end else begin
                     tx_data  <= RSP_BAD;
                     tx_valid <= 1'b1;
                     state    <= S_RESP_LO;
                  end
               end
            end
            S_GET_ADDR: begin
               if (rx_valid) begin
                  addr_q <= rx_data[ADDR_W-1:0];
                  if (is_wr_q) begin
                     state <= S_GET_DH;
                  end else begin
                     apb_paddr  <= rx_data[ADDR_W-1:0];
                     apb_pwrite <= 1'b0;
                     state      <= S_SETUP;
                  end
               end else if (cmd_expire) begin
                  state <= S_IDLE;
               end
            end
            S_GET_DH: begin
               if (rx_valid) begin
                  wd_hi_q <= rx_data;
                  state   <= S_GET_DL;
               end else if (cmd_expire) begin
                  state <= S_IDLE;
               end
            end
            S_GET_DL: begin
               if (rx_valid) begin
                  apb_paddr  <= addr_q;
                  apb_pwrite <= 1'b1;
                  wdata_q    <= {wd_hi_q, rx_data};
                  state      <= S_SETUP;
               end else if (cmd_expire) begin
                  state <= S_IDLE;
               end
            end
            S_SETUP: begin
               state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready_w) begin
                  tx_valid <= 1'b1;
                  if (pslverr_w) begin
                     tx_data <= RSP_ERR;
                     state   <= S_RESP_LO;
                  end else if (apb_pwrite) begin
                     tx_data <= RSP_ACK;
                     state   <= S_RESP_LO;
                  end else begin
                     tx_data <= apb_prdata[15:8];
                     rd_lo_q <= apb_prdata[7:0];
                     state   <= S_RESP_HI;
                  end
               end else if (acc_expire) begin
                  tx_data  <= RSP_TMO;
                  tx_valid <= 1'b1;
                  state    <= S_RESP_LO;
               end
            end
            S_RESP_HI: begin
               if (tx_fire) begin
                  tx_data <= rd_lo_q;
                  state   <= S_RESP_LO;
               end
            end
            S_RESP_LO: begin
               if (tx_fire) begin
                  tx_valid <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_micro_uart_apb_bridge.sv
// Directed bench for micro_uart_apb_bridge (CMD_TIMEOUT overridden to 16).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Response bytes are checked against exp_q in order.
module tb_micro_uart_apb_bridge;

   localparam int          ADDR_W = 4;
   localparam logic [15:0] TMO    = 16'd16;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd4;
   localparam logic [2:0] S_ACCESS  = 3'd5;
   localparam logic [2:0] S_RESP_HI = 3'd6;

   logic              clk;
   logic              reset_n;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_drop;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              apb_psel;
   logic              apb_penable;
   logic              apb_pwrite;
   logic [ADDR_W-1:0] apb_paddr;
   logic [31:0]       apb_pwdata;
   logic [31:0]       apb_prdata;
   logic [2:0]        dbg_state;
`ifdef MICRO_UART_APB_BRIDGE_PREADY_EN
   logic              apb_pready;
   logic              apb_pslverr;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int psel_cyc = 0;
   int pen_cyc  = 0;
   int drop_cnt = 0;
   int txv_cyc  = 0;
   int p0, e0, d0, t0;

   logic [7:0] exp_q[$];

   micro_uart_apb_bridge #(.ADDR_W(ADDR_W), .CMD_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_drop     (rx_drop),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_paddr   (apb_paddr),
      .apb_pwdata  (apb_pwdata),
      .apb_prdata  (apb_prdata),
`ifdef MICRO_UART_APB_BRIDGE_PREADY_EN
      .apb_pready  (apb_pready),
      .apb_pslverr (apb_pslverr),
`endif
      .dbg_state   (dbg_state)
   );

   // clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // bus monitor: activity counters and penable-implies-psel
   always @(negedge clk) begin
      if (reset_n) begin
         if (apb_psel)    psel_cyc++;
         if (apb_penable) pen_cyc++;
         if (rx_drop)     drop_cnt++;
         if (tx_valid)    txv_cyc++;
         if (apb_penable) check("pen_needs_sel", {31'd0, apb_psel}, 32'd1);
      end
   end

   // drivers (called at posedge+1, return at posedge+1)
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // wait for a response byte, keep tx_ready low for `hold` cycles, then accept it
   task automatic take_byte(input string tag, input int hold);
      logic [7:0] exp;
      int w;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      w = 0;
      @(negedge clk);
      while (!tx_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
      check(tag, {24'd0, tx_data}, {24'd0, exp});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_v"}, {31'd0, tx_valid}, 32'd1);
         check({tag, "_hold_d"}, {24'd0, tx_data}, {24'd0, exp});
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
   endtask

   task automatic snap();
      p0 = psel_cyc; e0 = pen_cyc; d0 = drop_cnt; t0 = txv_cyc;
   endtask

   initial begin
      reset_n    = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      tx_ready   = 1'b0;
      apb_prdata = 32'h0000_0000;
`ifdef MICRO_UART_APB_BRIDGE_PREADY_EN
      apb_pready  = 1'b1;
      apb_pslverr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_psel",   {31'd0, apb_psel},    32'd0);
      check("rst_pen",    {31'd0, apb_penable}, 32'd0);
      check("rst_txv",    {31'd0, tx_valid},    32'd0);
      check("rst_txd",    {24'd0, tx_data},     32'd0);
      check("rst_drop",   {31'd0, rx_drop},     32'd0);
      check("rst_paddr",  {28'd0, apb_paddr},   32'd0);
      check("rst_pwdata", apb_pwdata,           32'd0);
      check("rst_state",  {29'd0, dbg_state},   {29'd0, S_IDLE});
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // write 0x0003 to address 4
      snap();
      exp_q.push_back(8'h4B);
      send_byte(8'h57); send_byte(8'h04); send_byte(8'h00); send_byte(8'h03);
      @(negedge clk);
      check("wr_setup_state", {29'd0, dbg_state}, {29'd0, S_SETUP});
      check("wr_setup_psel",  {31'd0, apb_psel},    32'd1);
      check("wr_setup_pen",   {31'd0, apb_penable}, 32'd0);
      check("wr_pwrite",      {31'd0, apb_pwrite},  32'd1);
      check("wr_paddr",       {28'd0, apb_paddr},   32'h4);
      check("wr_pwdata",      apb_pwdata,           32'h0000_0003);
      @(negedge clk);
      check("wr_acc_psel",    {31'd0, apb_psel},    32'd1);
      check("wr_acc_pen",     {31'd0, apb_penable}, 32'd1);
      @(negedge clk);
      check("wr_end_psel",    {31'd0, apb_psel},    32'd0);
      check("wr_end_pen",     {31'd0, apb_penable}, 32'd0);
      check("wr_psel_cycles", psel_cyc - p0, 32'd2);
      check("wr_pen_cycles",  pen_cyc - e0,  32'd1);
      take_byte("wr_resp", 0);
      @(negedge clk);
      check("wr_txv_after", {31'd0, tx_valid}, 32'd0);
      check("wr_idle",      {29'd0, dbg_state}, {29'd0, S_IDLE});
      @(posedge clk); #1;

      // read 0x1281 from address 8, busy byte during RESP_HI, 10-cycle stall
      snap();
      apb_prdata = 32'h0000_1281;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h81);
      send_byte(8'h52); send_byte(8'h08);
      @(negedge clk);
      check("rd_setup_psel", {31'd0, apb_psel},   32'd1);
      check("rd_pwrite",     {31'd0, apb_pwrite}, 32'd0);
      check("rd_paddr",      {28'd0, apb_paddr},  32'h8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rd_resp_hi", {29'd0, dbg_state}, {29'd0, S_RESP_HI});
      send_byte(8'h55);
      @(negedge clk);
      check("drop_pulse", {31'd0, rx_drop}, 32'd1);
      check("drop_state", {29'd0, dbg_state}, {29'd0, S_RESP_HI});
      check("drop_txd",   {24'd0, tx_data}, 32'h12);
      @(negedge clk);
      check("drop_end",   {31'd0, rx_drop}, 32'd0);
      @(posedge clk); #1;
      take_byte("rd_hi", 10);
      take_byte("rd_lo", 0);
      check("rd_psel_cycles", psel_cyc - p0, 32'd2);
      check("rd_pen_cycles",  pen_cyc - e0,  32'd1);
      check("drop_count",     drop_cnt - d0, 32'd1);
      check("rd_pwrite_hold", {31'd0, apb_pwrite}, 32'd0);

      // bad opcode, then a read with upper prdata bits set and address truncation
      snap();
      exp_q.push_back(8'h3F);
      send_byte(8'h41);
      take_byte("bad_op", 0);
      check("bad_no_apb", psel_cyc - p0, 32'd0);
      apb_prdata = 32'hABCD_5A3C;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h3C);
      send_byte(8'h52); send_byte(8'hF7);
      @(negedge clk);
      check("trunc_paddr", {28'd0, apb_paddr}, 32'h7);
      @(posedge clk); #1;
      take_byte("rd2_hi", 0);
      take_byte("rd2_lo", 0);

      // partial write abandoned by timeout, then a normal read
      snap();
      send_byte(8'h57); send_byte(8'h04);
      idle(20);
      check("tmo_no_apb",   psel_cyc - p0, 32'd0);
      check("tmo_no_tx",    txv_cyc - t0,  32'd0);
      check("tmo_idle",     {29'd0, dbg_state}, {29'd0, S_IDLE});
      apb_prdata = 32'h0000_1281;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h81);
      send_byte(8'h52); send_byte(8'h00);
      take_byte("tmo_rd_hi", 0);
      take_byte("tmo_rd_lo", 0);

      // byte landing on the expiry cycle is still accepted
      snap();
      exp_q.push_back(8'h4B);
      send_byte(8'h57);
      idle(15);
      send_byte(8'h0A); send_byte(8'hBE); send_byte(8'hEF);
      take_byte("edge_wr", 0);
      check("edge_pen_cycles", pen_cyc - e0, 32'd1);
      check("hold_paddr",  {28'd0, apb_paddr}, 32'hA);
      check("hold_pwdata", apb_pwdata, 32'h0000_BEEF);
      check("hold_pwrite", {31'd0, apb_pwrite}, 32'd1);

      // one cycle later the command has expired; the byte is a fresh opcode
      snap();
      exp_q.push_back(8'h3F);
      send_byte(8'h52);
      idle(16);
      send_byte(8'h04);
      take_byte("late_byte", 0);
      check("late_no_apb", psel_cyc - p0, 32'd0);

      // reset while a read response is pending
      send_byte(8'h52); send_byte(8'h08);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_txv_before", {31'd0, tx_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_txv",   {31'd0, tx_valid}, 32'd0);
      check("mid_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
      @(posedge clk); #1;
      reset_n = 1'b1;
      snap();
      tx_ready = 1'b1;
      idle(6);
      tx_ready = 1'b0;
      check("mid_no_tx", txv_cyc - t0, 32'd0);

      // reset during ACCESS
      send_byte(8'h52); send_byte(8'h08);
      @(posedge clk); #1;
      check("acc_state", {29'd0, dbg_state}, {29'd0, S_ACCESS});
      reset_n = 1'b0;
      #1;
      check("acc_rst_psel", {31'd0, apb_psel},    32'd0);
      check("acc_rst_pen",  {31'd0, apb_penable}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      snap();
      idle(6);
      check("acc_rst_no_tx", txv_cyc - t0, 32'd0);
      check("exp_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
